// File: rtl/vote_sequencer.sv
// Three-voter ballot collector: gathers up to three ballots per round, then
// registers their bitwise majority along with dissent and missing-voter flags.
module vote_sequencer #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       vld,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic [2:0]       ack,
    output logic             busy,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    output logic             dissent,
    output logic [2:0]       missing
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VOTE    = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       timer;
    logic [2:0]       captured;
    logic [2:0]       take;
    logic             all_in;
    logic             timeout_hit;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] c_op;

    assign busy = (state != IDLE);

    // Absent voters take part in the vote as all-zero operands.
    assign a_op = captured[0] ? a_q : '0;
    assign b_op = captured[1] ? b_q : '0;
    assign c_op = captured[2] ? c_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        take        = 3'b000;
        all_in      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                take        = vld & ~captured;
                all_in      = &(captured | take);
                timeout_hit = (timer == TIMER_LAST);
                if (all_in || timeout_hit) begin
                    state_next = VOTE;
                end
            end
            VOTE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ack echoes exactly the voters captured on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= '0;
            captured <= '0;
            ack      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            O        <= '0;
            O_valid  <= 1'b0;
            dissent  <= 1'b0;
            missing  <= '0;
        end else begin
            ack     <= take;
            O_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timer    <= '0;
                        captured <= '0;
                    end
                end
                COLLECT: begin
                    timer    <= timer + 8'd1;
                    captured <= captured | take;
                    if (take[0]) a_q <= A;
                    if (take[1]) b_q <= B;
                    if (take[2]) c_q <= C;
                end
                VOTE: begin
                    O       <= (a_op & b_op) | (a_op & c_op) | (b_op & c_op);
                    dissent <= (a_op != b_op) | (a_op != c_op);
                    missing <= ~captured;
                    O_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/vote_sequencer.md
VOTE_SEQUENCER -- requirements
Module: vote_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the ballot and result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the number of COLLECT cycles before forced vote (legal range 2..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  opens a voting round; sampled in IDLE only.
REQ-007 vld  input  3  ballot valid, bit0=voter A, bit1=B, bit2=C; held high by voter until its ack.
REQ-008 A, B, C  input  WIDTH each  ballot data of voters A/B/C, stable while the matching vld bit is high.
REQ-009 ack  output  3  one-cycle pulse per voter confirming ballot capture.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 O  output  WIDTH  bitwise majority result of the last round.
REQ-012 O_valid  output  1  one-cycle pulse marking a new result.
REQ-013 dissent  output  1  last round's three operands not bitwise identical.
REQ-014 missing  output  3  voters whose ballot was absent in last round (bit order as vld).

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, VOTE; busy decoded from the state register.
REQ-016 IDLE: start=1 at an edge -> COLLECT; captured flags and timer cleared on that edge.
REQ-017 COLLECT: at each edge, every voter with vld=1 and not yet captured has its data registered and its captured flag set.
REQ-018 ack[i] SHALL be high for exactly the one cycle following the capturing edge of voter i; never more than once per round.
REQ-019 vld=1 from an already-captured voter, or any vld in IDLE/VOTE, SHALL be ignored and SHALL NOT produce ack.
REQ-020 timer SHALL increment on every COLLECT edge; COLLECT -> VOTE when all three captured (including those captured on the current edge) or when the edge is the TIMEOUT-th COLLECT edge.
REQ-021 Ballot arriving on the same edge as timeout SHALL be captured and counted; missing bit clear for it.
REQ-022 Uncaptured ballots SHALL contribute all-zero operands to the vote.
REQ-023 VOTE (exactly one cycle): at its edge register O = (a&b)|(a&c)|(b&c) per bit, dissent = (a!=b)|(a!=c), missing = ~captured, O_valid=1; next state IDLE.
REQ-024 O, dissent, missing SHALL hold their values until the next VOTE edge; O_valid SHALL drop after one cycle.
REQ-025 start while busy SHALL be ignored (not queued).
REQ-026 Latency: all ballots valid at first COLLECT edge -> O_valid high 2 cycles after the start edge; no ballots -> TIMEOUT+1 cycles after the start edge.
REQ-027 start high in the O_valid cycle (state IDLE) SHALL open a new round with no dead cycle.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE and clear timer, captured flags, ack, O, O_valid, dissent, missing to 0, overriding all other inputs, including mid-COLLECT and in VOTE.
REQ-029 A round interrupted by reset SHALL produce no O_valid and no further ack.

Verification (WIDTH=4, TIMEOUT=16)
REQ-030 start; next cycle vld=111, A=1100, B=1010, C=0110 -> ack=111 one cycle, O=1110, dissent=1, missing=000, O_valid 2 cycles after start.
REQ-031 start; vld A only then C, B never (A=C=0101) -> O_valid at cycle 17 after start, O=0101, missing=010, dissent=1.
REQ-032 start; B held valid throughout, second start during COLLECT -> single ack[1], start ignored, one O_valid per round.
REQ-033 start; C valid arriving on the 16th COLLECT edge -> ack[2] pulsed, missing bit2=0.
REQ-034 start; A captured; rst asserted mid-COLLECT -> all outputs 0, busy=0, no O_valid; subsequent full round works normally.
REQ-035 back-to-back: start in O_valid cycle, unanimous ballots 1111 -> second O_valid 2 cycles later, O=1111, dissent=0.
